// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: default timing constants, transmitter state encoding,
// and frame helpers used by the host transmitter (and the receiver).
package ps2_host_tx_pkg;

  localparam int unsigned PS2_INHIBIT_CYCLES = 3840;
  localparam int unsigned PS2_REQ_CYCLES     = 320;
  localparam int unsigned PS2_SAMPLE_DELAY   = 10;
  localparam int unsigned PS2_START_TIMEOUT  = 480000;
  localparam int unsigned PS2_FRAME_TIMEOUT  = 64000;
  localparam int unsigned PS2_FRAME_FALLS    = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SEND,
    ST_ACK,
    ST_RELEASE_WAIT
  } ps2_tx_state_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit the host presents after device fall idx: 1..8 data LSB first, 9 parity, 10 stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd8) begin
      return d[3'(idx - 4'd1)];
    end else if (idx == 4'd9) begin
      return p;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus debounce for one PS/2 line; emits filtered level
// and one-cycle fall/rise pulses when a new level is accepted.
module ps2_line_filter #(
  parameter int unsigned SAMPLE_DELAY = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        level_q, level_d;
  logic        fall_q, fall_d;
  logic        rise_q, rise_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    rise_d  = 1'b0;
    // A new level must persist for SAMPLE_DELAY consecutive cycles before it is taken.
    if (sync2_q != level_q) begin
      if (cnt_q == 16'(SAMPLE_DELAY - 1)) begin
        level_d = sync2_q;
        fall_d  = ~sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;
  assign rise  = rise_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, then
// shifts a command byte out on device clock falls and collects the ACK bit.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned REQ_CYCLES     = PS2_REQ_CYCLES,
  parameter int unsigned SAMPLE_DELAY   = PS2_SAMPLE_DELAY,
  parameter int unsigned START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int unsigned FRAME_TIMEOUT  = PS2_FRAME_TIMEOUT
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       kbd_clk,
  input  logic       kbd_dat,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       kbd_clk_oe,
  output logic       kbd_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  ps2_tx_state_e state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          dat_oe_q, dat_oe_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          dat_s1_q, dat_s1_d;
  logic          dat_s2_q, dat_s2_d;
  logic          timed_out;
  logic          clk_level, clk_fall, clk_rise;

  ps2_line_filter #(
    .SAMPLE_DELAY(SAMPLE_DELAY)
  ) u_clk_filter (
    .clk    (clk32),
    .rst_n  (rst_n),
    .line_in(kbd_clk),
    .level  (clk_level),
    .fall   (clk_fall),
    .rise   (clk_rise)
  );

  always_ff @(posedge clk32) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      dat_oe_q  <= dat_oe_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      error_q   <= error_d;
      dat_s1_q  <= dat_s1_d;
      dat_s2_q  <= dat_s2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    parity_d  = parity_q;
    dat_oe_d  = dat_oe_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    dat_s1_d  = kbd_dat;
    dat_s2_d  = dat_s1_q;
    // One timer serves both watchdogs: start window until fall 1, frame window after it.
    timed_out = (bit_cnt_q == '0) ? (cnt_q == 32'(START_TIMEOUT - 1))
                                  : (cnt_q == 32'(FRAME_TIMEOUT - 1));
    case (state_q)
      ST_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_start && !done_q) begin
          data_d    = tx_data;
          parity_d  = odd_parity(tx_data);
          bit_cnt_d = '0;
          cnt_d     = '0;
          nack_d    = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_REQUEST;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_REQUEST: begin
        if (cnt_q == 32'(REQ_CYCLES - 1)) begin
          cnt_d    = '0;
          dat_oe_d = 1'b1;
          state_d  = ST_SEND;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_SEND: begin
        if (timed_out) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          bit_cnt_d = '0;
          dat_oe_d  = 1'b0;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end else if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = (bit_cnt_q == '0) ? '0 : cnt_q + 32'd1;
          if (bit_cnt_q == 4'(PS2_FRAME_FALLS - 1)) begin
            nack_d   = dat_s2_q;
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end else begin
            dat_oe_d = ~frame_bit(data_q, parity_q, bit_cnt_q + 4'd1);
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_ACK, ST_RELEASE_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (timed_out) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          bit_cnt_d = '0;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end else if (state_q == ST_ACK) begin
          if (clk_rise) begin
            state_d = ST_RELEASE_WAIT;
          end
        end else if (clk_level && dat_s2_q) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          bit_cnt_d = '0;
          done_d    = 1'b1;
          error_d   = nack_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    kbd_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_REQUEST);
    kbd_dat_oe = (state_q == ST_REQUEST) || ((state_q == ST_SEND) && dat_oe_q);
    busy       = (state_q != ST_IDLE) || done_q;
    tx_done    = done_q;
    tx_error   = error_q;
  end

endmodule
